// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: decides advance/freeze/bubble/flush from
// load-use hazards, taken branches and data-cache stalls; keeps saturating stats.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_memread_i,
  input  logic [4:0]       IDEX_rt_i,
  input  logic [4:0]       IFID_rs_i,
  input  logic [4:0]       IFID_rt_i,
  input  logic             branch_taken_i,
  input  logic             dcache_stall_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_write_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic             miss_timeout_o
);

  typedef enum logic [1:0] {INIT, RUN, MISS} state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] miss_timer;
  logic [CNT_W-1:0] miss_timer_nxt;
  logic             lu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  assign lu = IDEX_memread_i && (IDEX_rt_i != 5'd0) &&
              ((IDEX_rt_i == IFID_rs_i) || (IDEX_rt_i == IFID_rt_i));

  assign miss_timer_nxt = sat_inc(miss_timer);

  // Controls are combinational so a hazard is answered in the same cycle.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_write_o  = 1'b1;
    if (state == INIT) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (dcache_stall_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      pipe_write_o  = 1'b0;
    end else if (lu) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= INIT;
      stall_cnt_o    <= '0;
      flush_cnt_o    <= '0;
      miss_cnt_o     <= '0;
      miss_timer     <= '0;
      miss_timeout_o <= 1'b0;
    end else begin
      if (state != INIT) begin
        if (!pc_write_o)  stall_cnt_o <= sat_inc(stall_cnt_o);
        if (ifid_flush_o) flush_cnt_o <= sat_inc(flush_cnt_o);
      end
      case (state)
        INIT: state <= RUN;
        RUN: begin
          if (dcache_stall_i) begin
            state      <= MISS;
            miss_cnt_o <= sat_inc(miss_cnt_o);
            miss_timer <= '0;
          end
        end
        MISS: begin
          miss_timer <= miss_timer_nxt;
          // Timer counts completed MISS cycles; flag only while the cache is still busy.
          if (dcache_stall_i && (miss_timer_nxt >= TIMEOUT_V)) miss_timeout_o <= 1'b1;
          if (!dcache_stall_i) state <= RUN;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
